// File: rtl/bram_port_arbiter.sv
// Two-requester, burst-aware round-robin arbiter for one BRAM port.
// Registers the BRAM command and tags in-flight reads so each response returns to its issuer.
module bram_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 64,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic              req0_last,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic              req1_last,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [1:0]        dbg_state
);
    // Handshake: a beat transfers on a cycle where reqN_valid && reqN_ready;
    // ready depends only on the grant state, never on valid.
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic [CNT_W-1:0]   cnt_after;

    logic               own_id;
    logic               own_valid;
    logic               oth_valid;
    logic               own_last;
    logic               own_we;
    logic [ADDR_W-1:0]  own_addr;
    logic [DATA_W-1:0]  own_wdata;
    logic               accept;
    logic               release_max;
    logic               release_any;

    logic [RD_LAT:0]    tag_v;
    logic [RD_LAT:0]    tag_id;

    // Owner view of the request inputs; other-side view is only its valid.
    always_comb begin
        own_id    = 1'b0;
        own_valid = 1'b0;
        oth_valid = 1'b0;
        own_last  = 1'b0;
        own_we    = 1'b0;
        own_addr  = req0_addr;
        own_wdata = req0_wdata;
        if (state == OWN0) begin
            own_valid = req0_valid;
            oth_valid = req1_valid;
            own_last  = req0_last;
            own_we    = req0_we;
        end else if (state == OWN1) begin
            own_id    = 1'b1;
            own_valid = req1_valid;
            oth_valid = req0_valid;
            own_last  = req1_last;
            own_we    = req1_we;
            own_addr  = req1_addr;
            own_wdata = req1_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        cnt_after    = beat_cnt + CNT_W'(accept);
        release_max  = (cnt_after == CNT_W'(MAX_BURST));
        release_any  = (accept && own_last) || release_max || (!own_valid && oth_valid);
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) state_nxt = rr_ptr ? OWN1 : OWN0;
                else if (req0_valid)          state_nxt = OWN0;
                else if (req1_valid)          state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                if (release_any) begin
                    rr_ptr_nxt   = ~own_id;
                    beat_cnt_nxt = '0;
                    // A burst cut at MAX_BURST with nobody waiting keeps the grant.
                    if (oth_valid)                state_nxt = own_id ? OWN0 : OWN1;
                    else if (accept && own_last)  state_nxt = IDLE;
                end else begin
                    beat_cnt_nxt = cnt_after;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == OWN0);
        req1_ready = (state == OWN1);
        accept     = (state != IDLE) && own_valid;
        rsp0_valid = tag_v[RD_LAT] && !tag_id[RD_LAT];
        rsp1_valid = tag_v[RD_LAT] &&  tag_id[RD_LAT];
        rsp0_rdata = bram_dout;
        rsp1_rdata = bram_dout;
        dbg_state  = state;
    end

    // Command register plus read-tag pipeline aligned to the BRAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bram_addr <= '0;
            bram_din  <= '0;
            bram_we   <= 1'b0;
            tag_v     <= '0;
            tag_id    <= '0;
        end else begin
            bram_we <= accept && own_we;
            if (accept) begin
                bram_addr <= own_addr;
                bram_din  <= own_wdata;
            end
            tag_v  <= {tag_v[RD_LAT-1:0], accept && !own_we};
            tag_id <= {tag_id[RD_LAT-1:0], own_id};
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed timing cases plus randomized bursts,
// with a shadow-memory reference model and per-requester expected-response queues.
module tb_bram_port_arbiter;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 64;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;
    localparam int EXP_W     = 32 + DATA_W;
    localparam int DEPTH     = 1 << ADDR_W;

    typedef struct packed {
        logic              we;
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } beat_t;

    logic              clk, rst;
    logic              req0_valid, req0_ready, req0_we, req0_last;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_ready, req1_we, req1_last;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_we;
    logic [DATA_W-1:0] bram_dout;
    logic [1:0]        dbg_state;

    bram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_last(req0_last), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_last(req1_last), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
        .bram_dout(bram_dout), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- BRAM behavioural model ----------------
    logic [DATA_W-1:0] bram_mem [DEPTH];
    logic [DATA_W-1:0] rd_pipe  [RD_LAT];
    always @(posedge clk) begin
        if (bram_we) bram_mem[bram_addr] <= bram_din;
        rd_pipe[0] <= bram_mem[bram_addr];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bram_dout = rd_pipe[RD_LAT-1];

    // ---------------- scoreboard state ----------------
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [EXP_W-1:0]  exp_q0[$];
    logic [EXP_W-1:0]  exp_q1[$];
    beat_t             drv_q0[$];
    beat_t             drv_q1[$];
    int                log_id[$];
    int                log_cyc[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                gap0 = 0, gap1 = 0;
    logic              acc0 = 1'b0, acc1 = 1'b0;
    logic              cmd_pend = 1'b0;
    beat_t             cmd_exp;
    logic [ADDR_W-1:0] held_addr = '0;
    logic [DATA_W-1:0] held_din = '0;
    logic [DATA_W-1:0] last_rsp0 = '0;
    int                wait0 = 0, wait1 = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    initial begin
        req0_valid = 0; req0_we = 0; req0_last = 0; req0_addr = '0; req0_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (acc0 && drv_q0.size() > 0) void'(drv_q0.pop_front());
            if (!rst && drv_q0.size() > 0 && $urandom_range(99, 0) >= gap0) begin
                req0_valid = 1; req0_we = drv_q0[0].we; req0_last = drv_q0[0].last;
                req0_addr = drv_q0[0].addr; req0_wdata = drv_q0[0].wdata;
            end else req0_valid = 0;
        end
    end

    initial begin
        req1_valid = 0; req1_we = 0; req1_last = 0; req1_addr = '0; req1_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (acc1 && drv_q1.size() > 0) void'(drv_q1.pop_front());
            if (!rst && drv_q1.size() > 0 && $urandom_range(99, 0) >= gap1) begin
                req1_valid = 1; req1_we = drv_q1[0].we; req1_last = drv_q1[0].last;
                req1_addr = drv_q1[0].addr; req1_wdata = drv_q1[0].wdata;
            end else req1_valid = 0;
        end
    end

    function automatic beat_t mk(input logic we, input logic last, input int addr, input logic [DATA_W-1:0] d);
        beat_t b;
        b.we = we; b.last = last; b.addr = ADDR_W'(addr); b.wdata = d;
        return b;
    endfunction

    // ---------------- reference model: reaction to one accepted beat ----------------
    task automatic accept_beat(input int id, input beat_t b);
        logic [31:0] due;
        due = 32'(cyc + 1 + RD_LAT);
        log_id.push_back(id);
        log_cyc.push_back(cyc);
        cmd_exp = b;
        if (b.we) ref_mem[b.addr] = b.wdata;
        else if (id == 0) exp_q0.push_back({due, ref_mem[b.addr]});
        else exp_q1.push_back({due, ref_mem[b.addr]});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst) begin
            cmd_pend = 0; acc0 = 0; acc1 = 0; wait0 = 0; wait1 = 0;
            held_addr = '0; held_din = '0;
        end else begin
            if (cmd_pend) begin
                check("bram_we", bram_we, cmd_exp.we);
                check("bram_addr", bram_addr, cmd_exp.addr);
                check("bram_din", bram_din, cmd_exp.wdata);
                held_addr = cmd_exp.addr;
                held_din  = cmd_exp.wdata;
            end else begin
                check("bram_we_idle", bram_we, 0);
                check("bram_addr_hold", bram_addr, held_addr);
                check("bram_din_hold", bram_din, held_din);
            end
            if (req0_ready && req1_ready) check("ready_excl", 1, 0);
            if (rsp0_valid && rsp1_valid) check("rsp_excl", 1, 0);

            if (rsp0_valid) begin
                last_rsp0 = rsp0_rdata;
                if (exp_q0.size() == 0) check("rsp0_unexpected", 1, 0);
                else begin
                    e = exp_q0.pop_front();
                    check("rsp0_data", rsp0_rdata, e[DATA_W-1:0]);
                    check("rsp0_cycle", cyc, e[EXP_W-1:DATA_W]);
                end
            end else if (exp_q0.size() > 0 && int'(exp_q0[0][EXP_W-1:DATA_W]) <= cyc) begin
                check("rsp0_missing", 0, 1);
                void'(exp_q0.pop_front());
            end
            if (rsp1_valid) begin
                if (exp_q1.size() == 0) check("rsp1_unexpected", 1, 0);
                else begin
                    e = exp_q1.pop_front();
                    check("rsp1_data", rsp1_rdata, e[DATA_W-1:0]);
                    check("rsp1_cycle", cyc, e[EXP_W-1:DATA_W]);
                end
            end else if (exp_q1.size() > 0 && int'(exp_q1[0][EXP_W-1:DATA_W]) <= cyc) begin
                check("rsp1_missing", 0, 1);
                void'(exp_q1.pop_front());
            end

            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            cmd_pend = acc0 || acc1;
            if (acc0) accept_beat(0, mk(req0_we, req0_last, int'(req0_addr), req0_wdata));
            if (acc1) accept_beat(1, mk(req1_we, req1_last, int'(req1_addr), req1_wdata));

            // A waiting requester is served within one burst plus the idle bubble.
            if (acc0) begin check("wait0_bound", wait0 <= MAX_BURST + 1, 1); wait0 = 0; end
            else if (req0_valid) wait0++;
            else wait0 = 0;
            if (acc1) begin check("wait1_bound", wait1 <= MAX_BURST + 1, 1); wait1 = 0; end
            else if (req1_valid) wait1++;
            else wait1 = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_bench();
        drv_q0.delete(); drv_q1.delete(); exp_q0.delete(); exp_q1.delete();
        log_id.delete(); log_cyc.delete();
        acc0 = 0; acc1 = 0; cmd_pend = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req0_ready"}, req0_ready, 0);
        check({tag, "_req1_ready"}, req1_ready, 0);
        check({tag, "_rsp0_valid"}, rsp0_valid, 0);
        check({tag, "_rsp1_valid"}, rsp1_valid, 0);
        check({tag, "_bram_addr"}, bram_addr, 0);
        check({tag, "_bram_din"}, bram_din, 0);
        check({tag, "_bram_we"}, bram_we, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        clear_bench();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        #1 rst = 0;
        @(negedge clk); #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((drv_q0.size() + drv_q1.size() + exp_q0.size() + exp_q1.size()) > 0 && n < budget) begin
            @(negedge clk); n++;
        end
        check("drain_pending", drv_q0.size() + drv_q1.size() + exp_q0.size() + exp_q1.size(), 0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    // Accepts must land on consecutive cycles s+1.. with requester ids given by id_bits.
    task automatic check_log(input string name, input int n, input int s, input logic [15:0] id_bits);
        check({name, "_count"}, log_id.size(), n);
        for (int k = 0; k < n && k < log_id.size(); k++) begin
            check({name, "_id"}, log_id[k], id_bits[k]);
            check({name, "_cycle"}, log_cyc[k], s + 1 + k);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s, n, issued0, issued1, cnt0, cnt1;
        logic [DATA_W-1:0] wd;
        rst = 1;
        for (int i = 0; i < DEPTH; i++) begin
            wd = {$urandom, $urandom};
            ref_mem[i] = wd;
            bram_mem[i] = wd;
        end

        // single read
        do_reset();
        s = cyc + 1;
        drv_q0.push_back(mk(0, 1, 'h010, '0));
        while (cyc < s + 2) @(negedge clk);
        check("t1_bram_addr", bram_addr, 'h010);
        check("t1_bram_we", bram_we, 0);
        check("t1_state_idle", dbg_state, 0);
        wait_drain(50);
        check_log("t1", 1, s, 16'h0000);

        // simultaneous bursts, no bubble on hand-over
        do_reset();
        s = cyc + 1;
        for (int k = 0; k < 3; k++) drv_q0.push_back(mk(0, k == 2, 'h100 + k, '0));
        for (int k = 0; k < 2; k++) drv_q1.push_back(mk(0, k == 1, 'h200 + k, '0));
        wait_drain(50);
        check_log("t2", 5, s, 16'b11000);

        // alternating single-beat reads
        log_id.delete(); log_cyc.delete();
        s = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            drv_q0.push_back(mk(0, 1, $urandom_range(DEPTH - 1, 0), '0));
            drv_q1.push_back(mk(0, 1, $urandom_range(DEPTH - 1, 0), '0));
        end
        wait_drain(60);
        check_log("t3", 8, s, 16'b10101010);

        // MAX_BURST cut with the other requester waiting
        log_id.delete(); log_cyc.delete();
        s = cyc + 1;
        for (int k = 0; k < 6; k++) drv_q1.push_back(mk(0, k == 5, 'h300 + k, '0));
        @(negedge clk); #1;
        drv_q0.push_back(mk(0, 1, 'h040, '0));
        wait_drain(60);
        check_log("t4a", 7, s, 16'b1101111);

        // MAX_BURST reached with nobody waiting: grant kept
        log_id.delete(); log_cyc.delete();
        s = cyc + 1;
        for (int k = 0; k < 6; k++) drv_q1.push_back(mk(0, k == 5, 'h320 + k, '0));
        wait_drain(60);
        check_log("t4b", 6, s, 16'b111111);

        // write then read back
        drv_q0.push_back(mk(1, 1, 'h7FF, 64'hDEADBEEF_CAFEF00D));
        wait_drain(50);
        drv_q0.push_back(mk(0, 1, 'h7FF, '0));
        wait_drain(50);
        check("t5_readback", last_rsp0, 64'hDEADBEEF_CAFEF00D);

        // asynchronous reset with reads in flight
        log_id.delete(); log_cyc.delete();
        drv_q0.push_back(mk(0, 0, 'h050, '0));
        drv_q0.push_back(mk(0, 1, 'h051, '0));
        n = 0;
        while (log_id.size() < 2 && n < 20) begin @(negedge clk); n++; end
        check("t6_issued", log_id.size(), 2);
        @(posedge clk); #2;
        rst = 1;
        clear_bench();
        #1;
        check_reset_outputs("t6_async");
        repeat (2) @(negedge clk);
        #1 rst = 0;
        for (int k = 0; k < RD_LAT + 2; k++) begin
            @(negedge clk);
            check("t6_no_rsp0", rsp0_valid, 0);
            check("t6_no_rsp1", rsp1_valid, 0);
        end
        #1;
        s = cyc + 1;
        drv_q0.push_back(mk(0, 1, 'h060, '0));
        drv_q1.push_back(mk(0, 1, 'h061, '0));
        wait_drain(50);
        check_log("t6_pref", 2, s, 16'b10);

        // randomized bursts with valid gaps
        log_id.delete(); log_cyc.delete();
        gap0 = 25; gap1 = 25;
        issued0 = 0; issued1 = 0;
        for (int b = 0; b < 40; b++) begin
            n = $urandom_range(6, 1);
            for (int k = 0; k < n; k++)
                drv_q0.push_back(mk($urandom_range(99, 0) < 30, k == n - 1,
                                    $urandom_range(DEPTH - 1, 0), {$urandom, $urandom}));
            issued0 += n;
            n = $urandom_range(6, 1);
            for (int k = 0; k < n; k++)
                drv_q1.push_back(mk($urandom_range(99, 0) < 30, k == n - 1,
                                    $urandom_range(DEPTH - 1, 0), {$urandom, $urandom}));
            issued1 += n;
        end
        wait_drain(5000);
        cnt0 = 0; cnt1 = 0;
        foreach (log_id[i]) if (log_id[i] == 0) cnt0++; else cnt1++;
        check("rand_beats0", cnt0, issued0);
        check("rand_beats1", cnt1, issued1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
